rede_io_bridge: RTL and testbench

- Peripheral-side partner of the float processor I/O ports; sits between external sample streams and the processor's decoded port strobes.
- Input side: one holding register per input port, loaded from an external valid/ready stream. The selected register is driven onto io_in while the processor strobes req_in[k].
- Output side: captures io_out on each out_en[k] strobe into a port-tagged FIFO, which drains to an external valid/ready stream.

---
 rtl/rede_io_pkg.sv | 29 ++
 rtl/rede_fifo.sv | 55 +++++
 rtl/rede_io_bridge.sv | 151 +++++++++++++++
 tb/tb_rede_io_bridge.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rede_io_pkg.sv
// Shared definitions for the rede I/O bridge: index widths, strobe decoding
// helpers and the default output-FIFO entry layout.
package rede_io_pkg;

  localparam int unsigned RIO_NUIOIN = 4;
  localparam int unsigned RIO_NUIOOU = 4;
  localparam int unsigned RIO_DW_IN  = 19;
  localparam int unsigned RIO_DW_OUT = 28;
  localparam int unsigned RIO_FDEPTH = 8;

  // Port-index width; never below 1 so single-port builds still have a field.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic onehot(input logic [31:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic logic multihot(input logic [31:0] v);
    return $countones(v) > 1;
  endfunction

  typedef struct packed {
    logic [idx_w(RIO_NUIOOU)-1:0] port;
    logic [RIO_DW_OUT-1:0]        data;
  } rio_entry_t;

endpackage

// File: rtl/rede_fifo.sv
// Synchronous FIFO; combinational read of the head entry, power-of-two depth.
module rede_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rptr];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign w_wr = push & (~full | (pop & ~empty));
  assign w_rd = pop & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= din;
  end

endmodule

// File: rtl/rede_io_bridge.sv
// Bridge between external sample streams and the float processor's I/O port
// strobes: per-port input holding registers and a port-tagged output FIFO.
module rede_io_bridge
  import rede_io_pkg::*;
#(
  parameter  int unsigned NUIOIN = RIO_NUIOIN,
  parameter  int unsigned NUIOOU = RIO_NUIOOU,
  parameter  int unsigned DW_IN  = RIO_DW_IN,
  parameter  int unsigned DW_OUT = RIO_DW_OUT,
  parameter  int unsigned FDEPTH = RIO_FDEPTH,
  localparam int unsigned PWI    = idx_w(NUIOIN),
  localparam int unsigned PWO    = idx_w(NUIOOU),
  localparam int unsigned CW     = $clog2(FDEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUIOIN-1:0]        req_in,
  output logic signed [DW_IN-1:0]  io_in,
  input  logic [NUIOOU-1:0]        out_en,
  input  logic signed [DW_OUT-1:0] io_out,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DW_IN-1:0]         s_data,
  input  logic [PWI-1:0]           s_port,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DW_OUT-1:0] m_data,
  output logic [PWO-1:0]           m_port,
  output logic [NUIOIN-1:0]        hold_vld,
  input  logic                     clr,
  output logic                     ovf,
  output logic                     unf,
  output logic                     err
);

  typedef struct packed {
    logic [PWO-1:0]    port;
    logic [DW_OUT-1:0] data;
  } entry_t;

  logic [DW_IN-1:0]  r_hold_data [NUIOIN];
  logic [NUIOIN-1:0] r_hold_vld;
  logic              r_ovf;
  logic              r_unf;
  logic              r_err;

  logic [NUIOIN-1:0] w_rd_sel;
  logic [NUIOIN-1:0] w_consume;
  logic [NUIOIN-1:0] w_load;
  logic              w_unf_set;
  logic              w_ovf_set;
  logic              w_err_set;
  logic              w_push_req;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [PWO-1:0]    w_wr_port;
  entry_t            w_din;
  entry_t            w_dout;

  // w_rd_sel[k] only when req_in is exactly bit k, so multi-hot reads select nothing.
  always_comb begin
    w_rd_sel = '0;
    io_in    = '0;
    for (int unsigned k = 0; k < NUIOIN; k++) begin
      w_rd_sel[k] = (req_in == (NUIOIN'(1) << k));
      if (w_rd_sel[k] && r_hold_vld[k]) io_in = r_hold_data[k];
    end
  end

  assign w_consume = w_rd_sel & r_hold_vld;
  assign w_unf_set = |(w_rd_sel & ~r_hold_vld);

  always_comb begin
    s_ready = 1'b0;
    w_load  = '0;
    if (32'(s_port) < NUIOIN) begin
      s_ready = ~r_hold_vld[s_port] | w_rd_sel[s_port];
      if (s_valid && s_ready) w_load[s_port] = 1'b1;
    end
  end

  always_comb begin
    w_wr_port = '0;
    for (int unsigned j = 0; j < NUIOOU; j++) begin
      if (out_en[j]) w_wr_port = PWO'(j);
    end
  end

  assign w_push_req = onehot(32'(out_en));
  assign w_err_set  = multihot(32'(req_in)) | multihot(32'(out_en));
  assign w_pop      = ~w_empty & m_ready;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & (w_count == CW'(FDEPTH)) & ~w_pop;
  assign w_din      = '{port: w_wr_port, data: io_out};

  // A load on the same port as a consume wins, so the flag stays set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_vld <= '0;
      for (int unsigned k = 0; k < NUIOIN; k++) r_hold_data[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUIOIN; k++) begin
        if (w_load[k]) begin
          r_hold_data[k] <= s_data;
          r_hold_vld[k]  <= 1'b1;
        end else if (w_consume[k]) begin
          r_hold_vld[k]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~clr);
      r_unf <= w_unf_set | (r_unf & ~clr);
      r_err <= w_err_set | (r_err & ~clr);
    end
  end

  rede_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign m_valid  = ~w_empty;
  assign m_data   = w_dout.data;
  assign m_port   = w_dout.port;
  assign hold_vld = r_hold_vld;
  assign ovf      = r_ovf;
  assign unf      = r_unf;
  assign err      = r_err;

endmodule

// File: tb/tb_rede_io_bridge.sv
// Directed bench for rede_io_bridge: hold/consume, load collisions, FIFO fill
// and overflow, strobe errors and asynchronous reset mid-transfer.
module tb_rede_io_bridge;

  localparam int unsigned NUIOIN = 4;
  localparam int unsigned NUIOOU = 4;
  localparam int unsigned DW_IN  = 19;
  localparam int unsigned DW_OUT = 28;
  localparam int unsigned FDEPTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUIOIN-1:0] req_in;
  logic [DW_IN-1:0]  io_in;
  logic [NUIOOU-1:0] out_en;
  logic [DW_OUT-1:0] io_out;
  logic              s_valid;
  logic              s_ready;
  logic [DW_IN-1:0]  s_data;
  logic [1:0]        s_port;
  logic              m_valid;
  logic              m_ready;
  logic [DW_OUT-1:0] m_data;
  logic [1:0]        m_port;
  logic [NUIOIN-1:0] hold_vld;
  logic              clr;
  logic              ovf;
  logic              unf;
  logic              err;

  int n_checks = 0;
  int n_errors = 0;

  rede_io_bridge #(
    .NUIOIN (NUIOIN),
    .NUIOOU (NUIOOU),
    .DW_IN  (DW_IN),
    .DW_OUT (DW_OUT),
    .FDEPTH (FDEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .io_in    (io_in),
    .out_en   (out_en),
    .io_out   (io_out),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_port   (s_port),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_port   (m_port),
    .hold_vld (hold_vld),
    .clr      (clr),
    .ovf      (ovf),
    .unf      (unf),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] port, input logic [DW_IN-1:0] val);
    s_valid = 1'b1;
    s_port  = port;
    s_data  = val;
    step();
    s_valid = 1'b0;
  endtask

  logic [DW_IN-1:0]  e_in;
  logic [DW_OUT-1:0] drain_exp [8];

  initial begin
    rst = 1'b0; req_in = '0; out_en = '0; io_out = '0;
    s_valid = 1'b0; s_data = '0; s_port = '0; m_ready = 1'b0; clr = 1'b0;
    step(); step();
    check("rst_hold_vld", 64'(hold_vld), 64'h0);
    check("rst_m_valid", 64'(m_valid), 64'h0);
    check("rst_io_in", 64'(io_in), 64'h0);
    check("rst_flags", 64'({ovf, unf, err}), 64'h0);
    rst = 1'b1;
    step();

    // load port 2 with -5, then consume it
    s_valid = 1'b1; s_port = 2'd2; e_in = -5; s_data = e_in;
    #1 check("ld_s_ready", 64'(s_ready), 64'h1);
    step();
    s_valid = 1'b0;
    check("ld_hold_vld", 64'(hold_vld), 64'h4);
    req_in = 4'b0100;
    #1 check("rd_io_in", 64'(io_in), 64'(e_in));
    step();
    req_in = '0;
    check("rd_consumed", 64'(hold_vld), 64'h0);
    check("rd_no_unf", 64'(unf), 64'h0);

    // read of an empty holding register
    req_in = 4'b0001;
    #1 check("unf_io_in", 64'(io_in), 64'h0);
    step();
    req_in = '0;
    check("unf_set", 64'(unf), 64'h1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("unf_clr", 64'(unf), 64'h0);

    // consume and reload port 1 in the same cycle
    load(2'd1, 19'd7);
    s_port = 2'd1;
    #1 check("held_not_ready", 64'(s_ready), 64'h0);
    req_in = 4'b0010; s_valid = 1'b1; s_data = 19'd9;
    #1 check("coll_io_in", 64'(io_in), 64'd7);
    check("coll_s_ready", 64'(s_ready), 64'h1);
    step();
    req_in = '0; s_valid = 1'b0;
    check("coll_hold_vld", 64'(hold_vld), 64'h2);
    req_in = 4'b0010;
    #1 check("coll_next_rd", 64'(io_in), 64'd9);
    step();
    req_in = '0;
    check("coll_drained", 64'(hold_vld), 64'h0);

    // fill the FIFO from port 3 with m_ready low
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      out_en = 4'b1000; io_out = 28'(i);
      if (i == 0) #1 check("lat_m_valid_pre", 64'(m_valid), 64'h0);
      step();
      if (i == 0) check("lat_m_valid_post", 64'(m_valid), 64'h1);
    end
    out_en = '0;
    check("full_m_port", 64'(m_port), 64'd3);
    check("full_m_data", 64'(m_data), 64'd0);
    check("full_no_ovf", 64'(ovf), 64'h0);
    out_en = 4'b1000; io_out = 28'd8;
    step();
    out_en = '0;
    check("ovf_set", 64'(ovf), 64'h1);
    check("ovf_head", 64'(m_data), 64'd0);
    out_en = 4'b1000; io_out = 28'd9; m_ready = 1'b1;
    #1 check("pp_head", 64'(m_data), 64'd0);
    step();
    out_en = '0;
    drain_exp = '{28'd1, 28'd2, 28'd3, 28'd4, 28'd5, 28'd6, 28'd7, 28'd9};
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_%0d_valid", i), 64'(m_valid), 64'h1);
      check($sformatf("drain_%0d_data", i), 64'(m_data), 64'(drain_exp[i]));
      step();
    end
    m_ready = 1'b0;
    check("drain_empty", 64'(m_valid), 64'h0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("ovf_clr", 64'(ovf), 64'h0);

    // multi-hot strobes
    load(2'd0, 19'd3);
    load(2'd1, 19'd4);
    req_in = 4'b0011;
    #1 check("err_io_in", 64'(io_in), 64'h0);
    step();
    req_in = '0;
    check("err_rd_set", 64'(err), 64'h1);
    check("err_hold_kept", 64'(hold_vld), 64'h3);
    check("err_no_unf", 64'(unf), 64'h0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("err_clr", 64'(err), 64'h0);
    out_en = 4'b0110; io_out = 28'd5;
    step();
    out_en = '0;
    check("err_wr_set", 64'(err), 64'h1);
    check("err_no_push", 64'(m_valid), 64'h0);

    // reset in the middle of traffic
    for (int i = 0; i < 3; i++) begin
      out_en = 4'b0010; io_out = 28'(10 + i);
      step();
    end
    out_en = '0;
    load(2'd2, 19'd17);
    load(2'd3, 19'd18);
    check("pre_rst_hold", 64'(hold_vld), 64'hF);
    check("pre_rst_m_port", 64'(m_port), 64'd1);
    check("pre_rst_m_data", 64'(m_data), 64'd10);
    req_in = 4'b0100;
    #1 check("pre_rst_io_in", 64'(io_in), 64'd17);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_m_valid", 64'(m_valid), 64'h0);
    check("mid_rst_hold", 64'(hold_vld), 64'h0);
    check("mid_rst_io_in", 64'(io_in), 64'h0);
    check("mid_rst_err", 64'(err), 64'h0);
    req_in = '0;
    step();
    rst = 1'b1;
    step(); step();
    check("post_rst_m_valid", 64'(m_valid), 64'h0);
    check("post_rst_hold", 64'(hold_vld), 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
